// File: rtl/spi_flash_pkg.sv
// Shared definitions for the byte-lane SPI flash responder.
// Holds the opcode values, the transaction FSM state type, the SPI byte and
// address widths, and a helper that formats the status register byte.
package spi_flash_pkg;

    localparam int unsigned SPIBITWIDE = 8;
    localparam int unsigned ADDR_WIDTH = 24;

    localparam logic [SPIBITWIDE-1:0] OP_READ    = 8'h01;
    localparam logic [SPIBITWIDE-1:0] OP_PROGRAM = 8'h02;
    localparam logic [SPIBITWIDE-1:0] OP_RDSR    = 8'h05;
    localparam logic [SPIBITWIDE-1:0] OP_WREN    = 8'h06;

    typedef enum logic [3:0] {
        StIdle,
        StCmd,
        StAddr0,
        StAddr1,
        StAddr2,
        StRdata,
        StWdata,
        StStat,
        StIgnore
    } state_t;

    // Status register layout: bit 1 is the write-enable latch, all else zero.
    function automatic logic [SPIBITWIDE-1:0] status_byte(input logic wel);
        return {6'b0, wel, 1'b0};
    endfunction

endpackage

// File: rtl/spi_byte_ram.sv
// Single-port DEPTH x 8 byte RAM: synchronous write, combinational read.
// Contents are not reset; they start as 8'hFF like erased flash.
// Ports:
//   clk   - write clock
//   we    - write enable
//   addr  - shared read/write byte address
//   wdata - byte to write
//   rdata - byte at addr (combinational)
module spi_byte_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH] = '{default: 8'hFF};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR flash responder running in the p_clk domain.
// Decodes command / 24-bit address / data bytes arriving a byte at a time on
// s_mosi (one byte per s_clk rise while s_css is low) and serves READ,
// PROGRAM, WREN and RDSR out of an internal byte RAM.
// Ports:
//   p_clk     - block clock
//   p_reset_n - asynchronous active-low reset
//   s_clk     - SPI byte clock from the master (asynchronous)
//   s_css     - chip select, active-low (asynchronous)
//   s_mosi    - command, address or data byte from the master
//   s_miso    - read or status byte to the master (registered)
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned WEL_REQUIRED = 0
) (
    input  logic       p_clk,
    input  logic       p_reset_n,
    input  logic       s_clk,
    input  logic       s_css,
    input  logic [7:0] s_mosi,
    output logic [7:0] s_miso
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Synchronizers plus one extra stage on s_clk/s_css for edge detection.
    logic       sclk_s1, sclk_s2, sclk_s3;
    logic       css_s1, css_s2, css_s3;
    logic [7:0] mosi_s1, mosi_s2;
    logic       strobe_q;
    logic [7:0] byte_q;

    logic sclk_rise, css_rise, css_fall;

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign css_rise  = css_s2 & ~css_s3;
    assign css_fall  = ~css_s2 & css_s3;

    always_ff @(posedge p_clk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_s3  <= 1'b0;
            css_s1   <= 1'b0;
            css_s2   <= 1'b0;
            css_s3   <= 1'b0;
            mosi_s1  <= '0;
            mosi_s2  <= '0;
            strobe_q <= 1'b0;
            byte_q   <= '0;
        end else begin
            sclk_s1  <= s_clk;
            sclk_s2  <= sclk_s1;
            sclk_s3  <= sclk_s2;
            css_s1   <= s_css;
            css_s2   <= css_s1;
            css_s3   <= css_s2;
            mosi_s1  <= s_mosi;
            mosi_s2  <= mosi_s1;
            strobe_q <= sclk_rise & ~css_s2;
            if (sclk_rise && !css_s2) begin
                byte_q <= mosi_s2;
            end
        end
    end

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_loaded;
    logic                  wel_q;
    logic                  is_read_q;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_rdata;

    assign addr_loaded = {addr_q[ADDR_WIDTH-1:8], byte_q};

    // The RAM address looks one step ahead so that the byte registered into
    // s_miso on a strobe is the one at the address being moved to.
    always_comb begin
        ram_addr = addr_q[AW-1:0];
        if (state_q == StAddr2) begin
            ram_addr = addr_loaded[AW-1:0];
        end else if (state_q == StRdata) begin
            ram_addr = addr_q[AW-1:0] + AW'(1);
        end
    end

    // A strobe that coincides with deselect is dropped.
    assign ram_we = (state_q == StWdata) && strobe_q && !css_rise &&
                    ((WEL_REQUIRED == 0) || wel_q);

    spi_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (p_clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (byte_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge p_clk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wel_q     <= 1'b0;
            is_read_q <= 1'b0;
            s_miso    <= 8'h00;
        end else if (css_rise) begin
            state_q <= StIdle;
            s_miso  <= 8'h00;
            if (state_q == StWdata) begin
                wel_q <= 1'b0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (css_fall) begin
                        state_q <= StCmd;
                    end
                end
                StCmd: begin
                    if (strobe_q) begin
                        case (byte_q)
                            OP_READ, OP_PROGRAM: begin
                                is_read_q <= (byte_q == OP_READ);
                                state_q   <= StAddr0;
                            end
                            OP_RDSR: begin
                                s_miso  <= status_byte(wel_q);
                                state_q <= StStat;
                            end
                            OP_WREN: begin
                                wel_q   <= 1'b1;
                                state_q <= StIgnore;
                            end
                            default: state_q <= StIgnore;
                        endcase
                    end
                end
                StAddr0: begin
                    if (strobe_q) begin
                        addr_q[23:16] <= byte_q;
                        state_q       <= StAddr1;
                    end
                end
                StAddr1: begin
                    if (strobe_q) begin
                        addr_q[15:8] <= byte_q;
                        state_q      <= StAddr2;
                    end
                end
                StAddr2: begin
                    if (strobe_q) begin
                        addr_q <= addr_loaded;
                        if (is_read_q) begin
                            s_miso  <= ram_rdata;
                            state_q <= StRdata;
                        end else begin
                            state_q <= StWdata;
                        end
                    end
                end
                StRdata: begin
                    if (strobe_q) begin
                        addr_q <= addr_q + 1'b1;
                        s_miso <= ram_rdata;
                    end
                end
                StWdata: begin
                    if (strobe_q) begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                StStat: begin
                    s_miso <= status_byte(wel_q);
                end
                StIgnore: begin
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder. Two instances share s_clk/s_mosi and
// have their own chip selects: dev0 with WEL_REQUIRED=0, dev1 with
// WEL_REQUIRED=1. Expected s_miso values come from a small memory/WEL model
// and are queued per byte, then popped 4 p_clk after that byte's s_clk rise.
module tb_spi_flash_responder;

    logic       p_clk = 1'b0;
    logic       p_reset_n = 1'b0;
    logic       s_clk = 1'b0;
    logic       css0 = 1'b1;
    logic       css1 = 1'b1;
    logic [7:0] s_mosi = 8'h00;
    logic [7:0] miso0, miso1;

    always #5 p_clk = ~p_clk;

    spi_flash_responder #(
        .DEPTH        (256),
        .WEL_REQUIRED (0)
    ) dut0 (
        .p_clk     (p_clk),
        .p_reset_n (p_reset_n),
        .s_clk     (s_clk),
        .s_css     (css0),
        .s_mosi    (s_mosi),
        .s_miso    (miso0)
    );

    spi_flash_responder #(
        .DEPTH        (256),
        .WEL_REQUIRED (1)
    ) dut1 (
        .p_clk     (p_clk),
        .p_reset_n (p_reset_n),
        .s_clk     (s_clk),
        .s_css     (css1),
        .s_mosi    (s_mosi),
        .s_miso    (miso1)
    );

    typedef struct packed {
        logic       chk;
        logic [7:0] val;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] model [2][256];
    logic       wel [2];

    function automatic logic [7:0] miso_of(input int dev);
        return (dev == 0) ? miso0 : miso1;
    endfunction

    function automatic logic [7:0] idx(input logic [23:0] a, input int i);
        return a[7:0] + 8'(i);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic chk, input logic [7:0] val);
        exp_t e;
        e.chk = chk;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic set_css(input int dev, input logic v);
        if (dev == 0) css0 = v;
        else css1 = v;
    endtask

    task automatic select_dev(input int dev);
        @(negedge p_clk);
        set_css(dev, 1'b0);
        repeat (6) @(negedge p_clk);
    endtask

    task automatic deselect_dev(input int dev, input string tag);
        @(negedge p_clk);
        set_css(dev, 1'b1);
        repeat (6) @(negedge p_clk);
        check(tag, miso_of(dev), 8'h00);
    endtask

    // One byte: 5 p_clk low with s_mosi set, then s_clk high for 5 p_clk.
    task automatic spi_byte(input int dev, input logic [7:0] b, input string tag);
        exp_t e;
        @(negedge p_clk);
        s_mosi = b;
        repeat (4) @(negedge p_clk);
        s_clk = 1'b1;
        repeat (4) @(posedge p_clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=%02h", tag, miso_of(dev));
        end else begin
            e = exp_q.pop_front();
            if (e.chk) check(tag, miso_of(dev), e.val);
        end
        @(negedge p_clk);
        s_clk = 1'b0;
    endtask

    task automatic do_program(input int dev, input logic [23:0] a,
                              input logic [7:0] d [4], input int n, input string tag);
        select_dev(dev);
        for (int i = 0; i < 4 + n; i++) push(1'b1, 8'h00);
        spi_byte(dev, 8'h02, tag);
        spi_byte(dev, a[23:16], tag);
        spi_byte(dev, a[15:8], tag);
        spi_byte(dev, a[7:0], tag);
        for (int i = 0; i < n; i++) begin
            spi_byte(dev, d[i], tag);
            if (dev == 0 || wel[dev]) model[dev][idx(a, i)] = d[i];
        end
        deselect_dev(dev, tag);
        wel[dev] = 1'b0;
    endtask

    task automatic do_read(input int dev, input logic [23:0] a, input int n,
                           input string tag);
        select_dev(dev);
        for (int i = 0; i < 3; i++) push(1'b1, 8'h00);
        push(1'b1, model[dev][idx(a, 0)]);
        for (int i = 1; i <= n; i++) push(i < n, model[dev][idx(a, i)]);
        spi_byte(dev, 8'h01, tag);
        spi_byte(dev, a[23:16], tag);
        spi_byte(dev, a[15:8], tag);
        spi_byte(dev, a[7:0], tag);
        for (int i = 0; i < n; i++) spi_byte(dev, 8'h00, tag);
        deselect_dev(dev, tag);
    endtask

    task automatic do_wren(input int dev);
        select_dev(dev);
        push(1'b1, 8'h00);
        spi_byte(dev, 8'h06, "wren");
        deselect_dev(dev, "wren_desel");
        wel[dev] = 1'b1;
    endtask

    task automatic do_rdsr(input int dev, input string tag);
        select_dev(dev);
        push(1'b1, {6'b0, wel[dev], 1'b0});
        push(1'b1, {6'b0, wel[dev], 1'b0});
        spi_byte(dev, 8'h05, tag);
        spi_byte(dev, 8'h00, tag);
        deselect_dev(dev, tag);
    endtask

    initial begin
        logic [7:0] d [4];
        for (int k = 0; k < 2; k++) begin
            wel[k] = 1'b0;
            for (int j = 0; j < 256; j++) model[k][j] = 8'hFF;
        end

        // Reset values
        repeat (3) @(negedge p_clk);
        check("reset_miso0", miso0, 8'h00);
        check("reset_miso1", miso1, 8'h00);
        p_reset_n = 1'b1;
        repeat (8) @(negedge p_clk);

        // Program and read back
        d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_program(0, 24'h000010, d, 4, "prog10");
        do_read(0, 24'h000010, 4, "read10");

        // Wrap from DEPTH-1 to 0
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_program(0, 24'h0000FE, d, 4, "progwrap");
        do_read(0, 24'h0000FE, 4, "readwrap");

        // Abort after the second address byte
        select_dev(0);
        for (int i = 0; i < 3; i++) push(1'b1, 8'h00);
        spi_byte(0, 8'h02, "abort");
        spi_byte(0, 8'h00, "abort");
        spi_byte(0, 8'h00, "abort");
        deselect_dev(0, "abort_desel");

        // Deselect arriving with the data strobe: byte must be discarded
        select_dev(0);
        for (int i = 0; i < 4; i++) push(1'b1, 8'h00);
        spi_byte(0, 8'h02, "race");
        spi_byte(0, 8'h00, "race");
        spi_byte(0, 8'h00, "race");
        spi_byte(0, 8'h10, "race");
        @(negedge p_clk);
        s_mosi = 8'h77;
        repeat (4) @(negedge p_clk);
        s_clk = 1'b1;
        @(negedge p_clk);
        css0 = 1'b1;
        repeat (4) @(negedge p_clk);
        s_clk = 1'b0;
        repeat (6) @(negedge p_clk);
        check("race_desel", miso0, 8'h00);
        wel[0] = 1'b0;
        do_read(0, 24'h000010, 1, "read_after_abort");

        // Reset in the middle of a READ
        select_dev(0);
        for (int i = 0; i < 3; i++) push(1'b1, 8'h00);
        push(1'b1, model[0][8'h10]);
        spi_byte(0, 8'h01, "rst_read");
        spi_byte(0, 8'h00, "rst_read");
        spi_byte(0, 8'h00, "rst_read");
        spi_byte(0, 8'h10, "rst_read");
        @(negedge p_clk);
        p_reset_n = 1'b0;
        #1;
        check("rst_async_miso0", miso0, 8'h00);
        repeat (3) @(negedge p_clk);
        p_reset_n = 1'b1;
        wel[0] = 1'b0;
        wel[1] = 1'b0;
        repeat (4) @(negedge p_clk);
        // Still selected but idle: further bytes must not shift out data.
        push(1'b1, 8'h00);
        spi_byte(0, 8'h00, "rst_idle");
        deselect_dev(0, "rst_desel");
        do_read(0, 24'h000010, 4, "read_after_rst");

        // WEL handling on the WEL_REQUIRED instance
        do_rdsr(1, "rdsr_init");
        do_wren(1);
        do_rdsr(1, "rdsr_wel");
        d = '{8'h55, 8'h00, 8'h00, 8'h00};
        do_program(1, 24'h000020, d, 1, "prog_wel");
        do_rdsr(1, "rdsr_cleared");
        d = '{8'hAA, 8'h00, 8'h00, 8'h00};
        do_program(1, 24'h000020, d, 1, "prog_nowel");
        do_read(1, 24'h000020, 1, "read_nowel");

        // Unknown opcode
        select_dev(1);
        for (int i = 0; i < 3; i++) push(1'b1, 8'h00);
        spi_byte(1, 8'h9F, "op9f");
        spi_byte(1, 8'h12, "op9f");
        spi_byte(1, 8'h34, "op9f");
        deselect_dev(1, "op9f_desel");
        do_read(1, 24'h000020, 1, "read_after_9f");
        do_wren(1);
        do_rdsr(1, "rdsr_after_9f");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
